// File: rtl/sccb_slave_regfile.sv
// sccb_slave_regfile: SCCB/I2C responder emulating the OV7670 register interface
//
// Ports:
//   clk          system clock, at least 16x the SCL frequency
//   rst          asynchronous active-high reset
//   scl_in       SCCB clock from the master (asynchronous)
//   sda_in       SDA pad input (asynchronous)
//   sda_oe       1 pulls SDA low (open-drain, pad driver external)
//   reg_wr_en    one-clk strobe per committed register write
//   reg_wr_addr  sub-address of the committed write
//   reg_wr_data  data of the committed write
//   busy         high from START until STOP
//   soft_rst     one-clk pulse when 0x12 is written with bit7 set
//
// Optional feature: define SCCB_AUTOINC_EN to step the sub-address pointer
// after every written byte and every ACKed read byte (burst access).
module sccb_slave_regfile #(
   parameter logic [6:0] DEV_ADDR = 7'h21,
   parameter int         FILT_LEN = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       reg_wr_en,
   output logic [7:0] reg_wr_addr,
   output logic [7:0] reg_wr_data,
   output logic       busy,
   output logic       soft_rst
);
`ifdef SCCB_AUTOINC_EN
   localparam logic [7:0] PTR_STEP = 8'd1;
`else
   localparam logic [7:0] PTR_STEP = 8'd0;
`endif

   typedef enum logic [3:0] {IDLE, DEV, ACK_DEV, SUB, ACK_SUB, WR, ACK_WR, RD, RD_ACK, IGNORE} state_t;

   state_t                state, state_n;
   logic [1:0]            scl_sy, sda_sy;
   logic [FILT_LEN-1:0]   scl_h, sda_h;
   logic                  scl_f, sda_f, scl_q, sda_q;
   logic                  scl_rise, scl_fall, start_c, stop_c, commit, load;
   logic [3:0]            bitcnt;
   logic [7:0]            shreg, ptr;
   logic [6:0]            rd_sh;
   logic [7:0]            regs [256];

   function automatic logic [7:0] dflt(input logic [7:0] a);
      return a == 8'h0A ? 8'h76 : a == 8'h0B ? 8'h73 : a == 8'h1C ? 8'h7F : a == 8'h1D ? 8'hA2 : 8'h00;
   endfunction

   function automatic logic ro(input logic [7:0] a);
      return a inside {8'h0A, 8'h0B, 8'h1C, 8'h1D};
   endfunction

   // Lines idle high, so the conditioning chain resets to 1 to avoid a false edge.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         scl_sy <= '1;
         sda_sy <= '1;
         scl_h  <= '1;
         sda_h  <= '1;
         scl_f  <= 1'b1;
         sda_f  <= 1'b1;
         scl_q  <= 1'b1;
         sda_q  <= 1'b1;
      end else begin
         scl_sy <= {scl_sy[0], scl_in};
         sda_sy <= {sda_sy[0], sda_in};
         scl_h  <= FILT_LEN'({scl_h, scl_sy[1]});
         sda_h  <= FILT_LEN'({sda_h, sda_sy[1]});
         scl_f  <= &scl_h ? 1'b1 : ~|scl_h ? 1'b0 : scl_f;
         sda_f  <= &sda_h ? 1'b1 : ~|sda_h ? 1'b0 : sda_f;
         scl_q  <= scl_f;
         sda_q  <= sda_f;
      end

   assign scl_rise = scl_f & ~scl_q;
   assign scl_fall = ~scl_f & scl_q;
   assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
   assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;
   assign commit   = scl_rise && state == ACK_WR;
   assign load     = state_n == RD && state != RD;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_n;

   // Byte phases end on the SCL fall after their 8th bit; ACK phases on the fall after the 9th.
   always_comb begin
      state_n = state;
      if (start_c)
         state_n = DEV;
      else if (stop_c)
         state_n = IDLE;
      else if (scl_fall)
         case (state)
            DEV:     if (bitcnt == 4'd8) state_n = shreg[7:1] == DEV_ADDR ? ACK_DEV : IGNORE;
            SUB:     if (bitcnt == 4'd8) state_n = ACK_SUB;
            WR:      if (bitcnt == 4'd8) state_n = ACK_WR;
            RD:      if (bitcnt == 4'd8) state_n = RD_ACK;
            ACK_DEV: state_n = shreg[0] ? RD : SUB;
            ACK_SUB: state_n = WR;
            ACK_WR:  state_n = WR;
            RD_ACK:  state_n = sda_f ? IGNORE : RD;
            default: state_n = state;
         endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bitcnt      <= '0;
         shreg       <= '0;
         ptr         <= '0;
         rd_sh       <= '0;
         sda_oe      <= 1'b0;
         busy        <= 1'b0;
         reg_wr_en   <= 1'b0;
         reg_wr_addr <= '0;
         reg_wr_data <= '0;
         soft_rst    <= 1'b0;
      end else begin
         reg_wr_en <= 1'b0;
         soft_rst  <= 1'b0;
         if (start_c || stop_c) begin
            bitcnt <= '0;
            sda_oe <= 1'b0;
            busy   <= start_c;
         end else if (scl_rise) begin
            if (state inside {DEV, SUB, WR})
               shreg <= {shreg[6:0], sda_f};
            if (state inside {DEV, SUB, WR, RD})
               bitcnt <= bitcnt + 4'd1;
            if (state == RD_ACK && !sda_f)
               ptr <= ptr + PTR_STEP;
            if (commit) begin
               reg_wr_en   <= 1'b1;
               reg_wr_addr <= ptr;
               reg_wr_data <= shreg;
               soft_rst    <= ptr == 8'h12 && shreg[7];
               ptr         <= ptr + PTR_STEP;
            end
         end else if (scl_fall) begin
            if (state_n != state)
               bitcnt <= '0;
            if (state == SUB && state_n == ACK_SUB)
               ptr <= shreg;
            // Read data: MSB driven on entry to RD, remaining bits shifted out on later falls.
            rd_sh  <= load ? regs[ptr][6:0] : {rd_sh[5:0], 1'b0};
            sda_oe <= state_n inside {ACK_DEV, ACK_SUB, ACK_WR} ? 1'b1 :
                      load ? ~regs[ptr][7] :
                      state_n == RD ? ~rd_sh[6] : 1'b0;
         end
      end

   // 0x12 bit7 is self-clearing; the following soft_rst cycle restores all defaults.
   always_ff @(posedge clk or posedge rst)
      if (rst)
         for (int i = 0; i < 256; i++) regs[i] <= dflt(8'(i));
      else if (soft_rst)
         for (int i = 0; i < 256; i++) regs[i] <= dflt(8'(i));
      else if (commit && !ro(ptr))
         regs[ptr] <= ptr == 8'h12 ? {1'b0, shreg[6:0]} : shreg;
endmodule

// File: tb/tb_sccb_slave_regfile.sv
// tb_sccb_slave_regfile: bus-level master, reference register model and scoreboard for sccb_slave_regfile
module tb_sccb_slave_regfile;
`ifdef SCCB_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic       clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_m = 1'b1;
   logic       sda_line, sda_oe, reg_wr_en, busy, soft_rst;
   logic [7:0] reg_wr_addr, reg_wr_data;

   assign sda_line = sda_m & ~sda_oe;

   sccb_slave_regfile dut (
      .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
      .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
      .busy(busy), .soft_rst(soft_rst)
   );

   always #5 clk = ~clk;

   int         checks = 0, errors = 0;
   logic [7:0] mem [256];
   logic [7:0] mptr = 8'h00;
   int         exp_soft = 0, soft_seen = 0, ign_hits = 0;
   bit         watch_ign = 1'b0;
   int         phase = 0;
   logic [15:0] wr_q [$];
   logic [7:0]  rd_q [$];
   logic        ack_q [$];
   logic [7:0]  txq [$];
   logic [7:0]  rd_acc = 8'h00;
   int          rd_n = 0;

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic miss(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: DUT output with no expectation queued", nm);
   endtask

   // Reference model: a plain 256-byte array plus a pointer.
   task automatic restore();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h0A] = 8'h76;
      mem[8'h0B] = 8'h73;
      mem[8'h1C] = 8'h7F;
      mem[8'h1D] = 8'hA2;
   endtask

   task automatic m_write(input logic [7:0] d);
      wr_q.push_back({mptr, d});
      if (!(mptr == 8'h0A || mptr == 8'h0B || mptr == 8'h1C || mptr == 8'h1D)) begin
         if (mptr == 8'h12 && d[7]) begin
            exp_soft++;
            restore();
         end else
            mem[mptr] = d;
      end
      if (AUTOINC) mptr = mptr + 8'd1;
   endtask

   task automatic m_read(input bit ack, output logic [7:0] r);
      r = mem[mptr];
      if (ack && AUTOINC) mptr = mptr + 8'd1;
   endtask

   // Monitors: ACK slots and read bits on SCL high, strobes on the falling clock edge.
   always @(posedge scl) begin
      #1;
      if (phase == 1) begin
         if (ack_q.size() == 0) miss("ack_slot");
         else chk("ack_slot", {15'd0, sda_oe}, {15'd0, ack_q.pop_front()});
      end else if (phase == 2) begin
         rd_acc = {rd_acc[6:0], sda_line};
         rd_n++;
         if (rd_n == 8) begin
            rd_n = 0;
            if (rd_q.size() == 0) miss("rd_byte");
            else chk("rd_byte", {8'd0, rd_acc}, {8'd0, rd_q.pop_front()});
         end
      end
   end

   always @(negedge clk) begin
      if (reg_wr_en) begin
         if (wr_q.size() == 0) miss("reg_wr");
         else chk("reg_wr", {reg_wr_addr, reg_wr_data}, wr_q.pop_front());
      end
      if (soft_rst) soft_seen++;
      if (watch_ign && sda_oe) ign_hits++;
   end

   // Bus master: 32 clk per SCL period, SDA changed in the middle of SCL low.
   task automatic bit_t(input logic b);
      #80 sda_m = b;
      #80 scl = 1'b1;
      #160 scl = 1'b0;
   endtask

   task automatic do_start();
      #80 sda_m = 1'b1;
      #80 scl = 1'b1;
      #80 sda_m = 1'b0;
      #80 scl = 1'b0;
   endtask

   task automatic do_stop();
      #80 sda_m = 1'b0;
      #80 scl = 1'b1;
      #80 sda_m = 1'b1;
      #80;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic ea);
      for (int i = 7; i >= 0; i--) bit_t(d[i]);
      ack_q.push_back(ea);
      phase = 1;
      bit_t(1'b1);
      phase = 0;
   endtask

   task automatic recv_byte(input logic last);
      phase = 2;
      for (int i = 0; i < 8; i++) bit_t(1'b1);
      phase = 0;
      bit_t(last);
   endtask

   task automatic wr_txn(input logic [7:0] sub);
      do_start();
      send_byte(8'h42, 1'b1);
      mptr = sub;
      send_byte(sub, 1'b1);
      foreach (txq[i]) begin
         m_write(txq[i]);
         send_byte(txq[i], 1'b1);
      end
      do_stop();
      txq.delete();
   endtask

   task automatic rd_txn(input logic [7:0] sub, input int n);
      logic [7:0] r;
      do_start();
      send_byte(8'h42, 1'b1);
      mptr = sub;
      send_byte(sub, 1'b1);
      do_stop();
      do_start();
      send_byte(8'h43, 1'b1);
      for (int i = 0; i < n; i++) begin
         m_read(i < n - 1, r);
         rd_q.push_back(r);
         recv_byte(i == n - 1);
      end
      do_stop();
   endtask

   initial begin
      logic [7:0] ro_tab [4];
      logic [7:0] sub;
      int         n;
      ro_tab = '{8'h0A, 8'h0B, 8'h1C, 8'h1D};
      restore();
      #103 rst = 1'b0;
      #200;
      chk("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
      chk("rst_wr_en", {15'd0, reg_wr_en}, 16'd0);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_soft", {15'd0, soft_rst}, 16'd0);

      txq = '{8'h80};
      wr_txn(8'h40);
      rd_txn(8'h40, 1);

      rd_txn(8'h1C, 1);
      txq = '{8'h55};
      wr_txn(8'h1C);
      rd_txn(8'h1C, 1);

      do_start();
      watch_ign = 1'b1;
      send_byte(8'h40, 1'b0);
      chk("ign_busy", {15'd0, busy}, 16'd1);
      send_byte(8'h12, 1'b0);
      send_byte(8'h80, 1'b0);
      watch_ign = 1'b0;
      do_stop();
      #100;
      chk("ign_busy_stop", {15'd0, busy}, 16'd0);
      chk("ign_oe_hits", ign_hits[15:0], 16'd0);

      txq = '{8'h0D};
      wr_txn(8'h3A);
      txq = '{8'h80};
      wr_txn(8'h12);
      chk("soft_pulses", soft_seen[15:0], exp_soft[15:0]);
      rd_txn(8'h3A, 1);
      rd_txn(8'h12, 1);
      rd_txn(8'h0A, 1);

      do_start();
      send_byte(8'h42, 1'b1);
      send_byte(8'h70, 1'b1);
      for (int i = 0; i < 4; i++) bit_t(1'($urandom_range(0, 1)));
      txq = '{8'h3A};
      wr_txn(8'h71);
      rd_txn(8'h70, 1);
      rd_txn(8'h71, 1);

      txq = '{8'h11, 8'h22};
      wr_txn(8'hFF);
      rd_txn(8'hFF, 1);
      rd_txn(8'h00, 1);
      rd_txn(8'h0A, 3);

      txq = '{8'h5A};
      wr_txn(8'h40);
      do_start();
      send_byte(8'h42, 1'b1);
      for (int i = 7; i >= 0; i--) bit_t(i == 6);
      #150;
      chk("oe_ack_pre_rst", {15'd0, sda_oe}, 16'd1);
      rst = 1'b1;
      #1;
      chk("oe_async_rst", {15'd0, sda_oe}, 16'd0);
      chk("busy_async_rst", {15'd0, busy}, 16'd0);
      restore();
      mptr = 8'h00;
      sda_m = 1'b1;
      #80 scl = 1'b1;
      #200 rst = 1'b0;
      #200;
      rd_txn(8'h40, 1);

      for (int k = 0; k < 10; k++) begin
         sub = $urandom_range(0, 3) == 0 ? ro_tab[$urandom_range(0, 3)] : 8'($urandom_range(0, 255));
         n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) txq.push_back(8'($urandom_range(0, 255)));
         wr_txn(sub);
         rd_txn(sub, n);
      end

      #200;
      chk("wr_q_drained", wr_q.size(), 16'd0);
      chk("rd_q_drained", rd_q.size(), 16'd0);
      chk("ack_q_drained", ack_q.size(), 16'd0);
      chk("soft_total", soft_seen[15:0], exp_soft[15:0]);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sccb_slave_regfile.md
Name: sccb_slave_regfile

Overview:
- SCCB/I2C responder that emulates the OV7670 register interface: accepts 3-phase writes (ID, sub-address, data) and 2-phase write + 2-phase read sequences from the camera-config master.
- Holds a 256x8 register file with camera ID defaults.
- Used as the camera stand-in in simulation and on-board loopback, so the config master and LUT can be checked without a sensor.

Parameters:
DEV_ADDR, 7'h21, 7-bit slave address (write byte 0x42, read byte 0x43)
FILT_LEN, 3, samples SCL/SDA must be stable before a level is accepted (glitch filter)

Ports:
clk  in  1  system clock; must be >= 16x SCL frequency
rst  in  1  asynchronous, active-high reset
scl_in  in  1  SCCB clock from master (asynchronous)
sda_in  in  1  SCCB data pad input (asynchronous)
sda_oe  out  1  1 = pull SDA low (open-drain); pad driver external
reg_wr_en  out  1  one-clk strobe per committed register write
reg_wr_addr  out  8  sub-address of committed write
reg_wr_data  out  8  data of committed write
busy  out  1  high from START until STOP
soft_rst  out  1  one-clk pulse when 0x12 is written with bit7 = 1

Behaviour:
- Reset: all outputs 0; FSM in IDLE; sub-address pointer 0x00; register file at defaults.
- Register defaults: 0x00 everywhere except 0x0A=0x76, 0x0B=0x73, 0x1C=0x7F, 0x1D=0xA2, 0x12=0x00.
- Read-only registers: 0x0A, 0x0B, 0x1C, 0x1D. Writes to them are ACKed but not stored, and reg_wr_en still pulses.
- Input conditioning: 2-FF synchroniser, then FILT_LEN glitch filter. Edge flags are valid 2+FILT_LEN clks after the pin edge.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high.
  - START from any state (including repeated start): enter DEV, clear bit counter.
  - STOP from any state: enter IDLE, sda_oe=0, busy=0.
- Bit sampling: data is sampled on SCL rising edge, MSB first. sda_oe changes only on SCL falling edge (+1 clk).
- FSM states and transitions:
  - IDLE: wait for START.
  - DEV: shift 8 bits.
    - addr==DEV_ADDR and R/W=0 -> ACK_DEV, then SUB.
    - addr==DEV_ADDR and R/W=1 -> ACK_DEV, then RD.
    - mismatch -> IGNORE (no ACK, sda_oe stays 0, wait for STOP/START).
  - ACK_DEV / ACK_SUB / ACK_WR: sda_oe=1 from the SCL falling edge after bit 8 to the SCL falling edge after bit 9.
  - SUB: shift 8 bits into the pointer -> ACK_SUB -> WR.
  - WR: shift 8 bits -> ACK_WR. At the 9th SCL rising edge: store byte (unless read-only), pulse reg_wr_en with pointer/data.
    - If pointer==0x12 and data[7]=1: pulse soft_rst, then restore defaults on the following clk. The stored 0x12 value is data & 0x7F.
    - Without auto-increment, further bytes overwrite the same address.
  - RD: load reg[pointer] at the SCL falling edge after ACK_DEV. Drive bit n as sda_oe = ~bit, MSB first. Release SDA for the 9th (master ACK/NACK) bit.
    - Master NACK -> IGNORE.
    - Master ACK -> reload the same address and continue.
- Mid-byte START/STOP discards the partial byte. No write is committed.
- busy: set on START, cleared on STOP or reset.
- Reset asserted mid-transfer: sda_oe released asynchronously; register file restored to defaults.
- Simultaneous soft_rst and new START: the default restore takes priority for that clk; the FSM still advances.

Optional Feature:
SCCB_AUTOINC_EN
- Defined: the pointer increments (mod 256, 0xFF wraps to 0x00) after each WR byte and after each ACKed RD byte, allowing burst access.
- Undefined: the pointer stays fixed; burst writes overwrite one address and burst reads repeat one value.

Test Plan:
- Write 0x42,0x40,0x80 + STOP -> three ACK slots with sda_oe=1; reg_wr_en pulses once with addr 0x40, data 0x80; later read of 0x40 returns 0x80.
- Write 0x42,0x1C + STOP, then 0x43, read + NACK -> SDA shows 0x7F; write 0x42,0x1C,0x55 -> ACKed, reg_wr_en pulses, readback still 0x7F.
- Write 0x40 (wrong address) ... -> sda_oe never asserts; no reg_wr_en; busy high until STOP.
- Write 0x3A=0x0D, then 0x12=0x80 -> soft_rst pulses once; readback 0x3A=0x00, 0x12=0x00, 0x0A=0x76.
- START after 4 data bits of a write to 0x70, then a full write 0x42,0x71,0x3A -> nothing stored at 0x70; 0x71=0x3A.
- With SCCB_AUTOINC_EN: write 0x42,0xFF,0x11,0x22 -> 0xFF=0x11, 0x00=0x22. Without it: 0xFF=0x22, 0x00 unchanged.
